// File: rtl/serial_frame_pkg.sv
// Shared types and line levels for the serial frame receiver.
// Optional parity support is selected with SERIAL_FRAME_RX_PARITY_EN.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic START_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b0;

endpackage

// File: rtl/serial_frame_hold.sv
// Single-entry valid/ready holding register with sticky overrun flag and parity tag.
// The tag is only meaningful when SERIAL_FRAME_RX_PARITY_EN is defined in the top.
module serial_frame_hold
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_commit,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_perr,
  input  logic             i_ready,
  input  logic             i_ovr_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_perr,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_perr;
  logic             r_overrun;
  logic             w_room;

  // A slot frees up on the same edge a pop happens, so a full buffer can still accept.
  assign w_room = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (i_commit && w_room) begin
        r_data  <= i_word;
        r_perr  <= i_perr;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end

      if (i_commit && !w_room) begin
        r_overrun <= 1'b1;
      end else if (i_ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_perr    = r_perr;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits, optional even parity.
// Define SERIAL_FRAME_RX_PARITY_EN to add the parity bit and the out_perr tag.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_perr,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_commit;
  logic [WIDTH-1:0] w_word;
  logic             w_perr;

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shift_nxt = {r_shift[WIDTH-2:0], serial_in};
    end else begin : g_lsb
      assign w_shift_nxt = {serial_in, r_shift[WIDTH-1:1]};
    end
  endgenerate

`ifdef SERIAL_FRAME_RX_PARITY_EN
  // Word is complete in r_shift; the parity bit is on the line this cycle.
  assign w_commit = (r_state == PARITY);
  assign w_word   = r_shift;
  assign w_perr   = (^r_shift) ^ serial_in;
`else
  // Commit the last data bit straight from the line so latency stays at WIDTH edges.
  assign w_commit = (r_state == SHIFT) && (r_cnt == LAST_BIT);
  assign w_word   = w_shift_nxt;
  assign w_perr   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= {WIDTH{IDLE_LEVEL}};
    end else begin
      case (r_state)
        IDLE: begin
          if (serial_in == START_LEVEL) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          r_shift <= w_shift_nxt;
          if (r_cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            r_cnt   <= r_cnt + CW'(1);
            r_state <= PARITY;
`else
            r_cnt   <= '0;
            r_state <= IDLE;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PARITY: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == SHIFT) || (r_state == PARITY);

  serial_frame_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .i_commit (w_commit),
    .i_word   (w_word),
    .i_perr   (w_perr),
    .i_ready  (out_ready),
    .i_ovr_clr(overrun_clr),
    .o_data   (out_data),
    .o_valid  (out_valid),
    .o_perr   (out_perr),
    .o_overrun(overrun)
  );

endmodule
